pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_slot.sv | 43 ++++
 rtl/pipe_skid_reg.sv | 131 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and entry type for the write-back skid register slice.
package pipe_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_REG_ADDR_W = 5;
    localparam int unsigned DEF_PAYLOAD_W  = 8;

    localparam logic [DEF_REG_ADDR_W-1:0] NOP_WD    = '0;
    localparam logic [DEF_DATA_W-1:0]     ZERO_WORD = '0;

    typedef struct packed {
        logic [DEF_REG_ADDR_W-1:0] wd;
        logic                      wreg;
        logic [DEF_DATA_W-1:0]     wdata;
        logic [DEF_PAYLOAD_W-1:0]  payload;
    } entry_t;

endpackage

// File: rtl/pipe_slot.sv
// One entry register with load/clear; a cleared or reset slot holds all-zero data.
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d,  data_q;

    // Clear wins over load so a flush never leaves stale data behind.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register slice for write-back entries (head + skid, in order).
// Optional bypass outputs enabled by macro PIPE_SKID_FWD_EN.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PAYLOAD_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_wd,
    input  logic                  in_wreg,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_wd,
    output logic                  out_wreg,
    output logic [DATA_W-1:0]     out_wdata,
    output logic [PAYLOAD_W-1:0]  out_payload,
    output logic [1:0]            occupancy
`ifdef PIPE_SKID_FWD_EN
   ,output logic                  fwd_wreg,
    output logic [REG_ADDR_W-1:0] fwd_wd,
    output logic [DATA_W-1:0]     fwd_wdata
`endif
);

    localparam int unsigned ENTRY_W = PAYLOAD_W + DATA_W + 1 + REG_ADDR_W;

    logic [ENTRY_W-1:0] in_entry, head_in, head_q, skid_q;
    logic               head_v, skid_v, head_v_d, skid_v_d;
    logic               head_load, head_clear, skid_load, skid_clear;
    logic               push, pop;
    logic [1:0]         occ_d, occ_q;

    assign in_entry = {in_payload, in_wdata, in_wreg, in_wd};
    assign in_ready = ~skid_v;
    assign push     = in_valid & in_ready;
    assign pop      = head_v & out_ready;
    assign head_in  = skid_v ? skid_q : in_entry;

    // Slot control; flush overrides everything, skid only fills when the head stalls.
    always_comb begin
        head_load  = 1'b0;
        head_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        head_v_d   = head_v;
        skid_v_d   = skid_v;
        if (flush) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
            head_v_d   = 1'b0;
            skid_v_d   = 1'b0;
        end else if (skid_v) begin
            if (pop) begin
                head_load  = 1'b1;
                skid_clear = 1'b1;
                skid_v_d   = 1'b0;
            end
        end else if (head_v) begin
            if (push && pop) begin
                head_load = 1'b1;
            end else if (push) begin
                skid_load = 1'b1;
                skid_v_d  = 1'b1;
            end else if (pop) begin
                head_clear = 1'b1;
                head_v_d   = 1'b0;
            end
        end else if (push) begin
            head_load = 1'b1;
            head_v_d  = 1'b1;
        end
        occ_d = 2'(head_v_d) + 2'(skid_v_d);
    end

    always_ff @(posedge clk) begin
        if (rst) occ_q <= 2'd0;
        else     occ_q <= occ_d;
    end

    pipe_slot #(.W(ENTRY_W)) u_head (
        .clk   (clk),
        .rst   (rst),
        .load  (head_load),
        .clear (head_clear),
        .d     (head_in),
        .valid (head_v),
        .q     (head_q)
    );

    pipe_slot #(.W(ENTRY_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_entry),
        .valid (skid_v),
        .q     (skid_q)
    );

    // Head slot is zero whenever invalid, so outputs form a NOP bubble for free.
    assign out_valid = head_v;
    assign {out_payload, out_wdata, out_wreg, out_wd} = head_q;
    assign occupancy = occ_q;

`ifdef PIPE_SKID_FWD_EN
    // Youngest valid entry feeds the bypass network.
    always_comb begin
        fwd_wreg  = 1'b0;
        fwd_wd    = REG_ADDR_W'(NOP_WD);
        fwd_wdata = DATA_W'(ZERO_WORD);
        if (skid_v) begin
            fwd_wd    = skid_q[REG_ADDR_W-1:0];
            fwd_wreg  = skid_q[REG_ADDR_W];
            fwd_wdata = skid_q[REG_ADDR_W+1 +: DATA_W];
        end else if (head_v) begin
            fwd_wd    = head_q[REG_ADDR_W-1:0];
            fwd_wreg  = head_q[REG_ADDR_W];
            fwd_wdata = head_q[REG_ADDR_W+1 +: DATA_W];
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (covers PIPE_SKID_FWD_EN when defined).
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_wreg, out_valid, out_ready, out_wreg;
    logic [4:0]  in_wd, out_wd;
    logic [31:0] in_wdata, out_wdata;
    logic [7:0]  in_payload, out_payload;
    logic [1:0]  occupancy;
`ifdef PIPE_SKID_FWD_EN
    logic        fwd_wreg;
    logic [4:0]  fwd_wd;
    logic [31:0] fwd_wdata;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wd       (in_wd),
        .in_wreg     (in_wreg),
        .in_wdata    (in_wdata),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_wd      (out_wd),
        .out_wreg    (out_wreg),
        .out_wdata   (out_wdata),
        .out_payload (out_payload),
        .occupancy   (occupancy)
`ifdef PIPE_SKID_FWD_EN
       ,.fwd_wreg    (fwd_wreg),
        .fwd_wd      (fwd_wd),
        .fwd_wdata   (fwd_wdata)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input entry_t e);
        in_valid   = v;
        in_wd      = e.wd;
        in_wreg    = e.wreg;
        in_wdata   = e.wdata;
        in_payload = e.payload;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"},   64'(out_valid),   64'd0);
        chk({tag, ".wd"},      64'(out_wd),      64'd0);
        chk({tag, ".wreg"},    64'(out_wreg),    64'd0);
        chk({tag, ".wdata"},   64'(out_wdata),   64'd0);
        chk({tag, ".payload"}, 64'(out_payload), 64'd0);
        chk({tag, ".occ"},     64'(occupancy),   64'd0);
        chk({tag, ".in_rdy"},  64'(in_ready),    64'd1);
    endtask

    entry_t e_nop, e_a, e_b, e_x;

    initial begin
        e_nop = '0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, e_nop);
        step(); step();
        rst = 1'b0;
        step();
        chk_empty("reset");

        // Single entry with latency 1, then a bubble.
        out_ready = 1'b1;
        e_a = '{wd: 5'd5, wreg: 1'b1, wdata: 32'hDEADBEEF, payload: 8'hA5};
        drive(1'b1, e_a);
        step();
        drive(1'b0, e_nop);
        chk("single.valid",   64'(out_valid),   64'd1);
        chk("single.wd",      64'(out_wd),      64'd5);
        chk("single.wreg",    64'(out_wreg),    64'd1);
        chk("single.wdata",   64'(out_wdata),   64'hDEADBEEF);
        chk("single.payload", 64'(out_payload), 64'hA5);
        chk("single.occ",     64'(occupancy),   64'd1);
        step();
        chk_empty("bubble");

        // Stall: A then B fill both slots; drain in order.
        out_ready = 1'b0;
        e_a = '{wd: 5'd1, wreg: 1'b1, wdata: 32'h111, payload: 8'h01};
        e_b = '{wd: 5'd2, wreg: 1'b0, wdata: 32'h222, payload: 8'h02};
        drive(1'b1, e_a);
        step();
        chk("stall1.occ",    64'(occupancy), 64'd1);
        chk("stall1.in_rdy", 64'(in_ready),  64'd1);
        drive(1'b1, e_b);
        step();
        drive(1'b0, e_nop);
        chk("stall2.occ",    64'(occupancy), 64'd2);
        chk("stall2.in_rdy", 64'(in_ready),  64'd0);
        chk("stall2.wd",     64'(out_wd),    64'd1);
        chk("stall2.wdata",  64'(out_wdata), 64'h111);
        out_ready = 1'b1;
        step();
        chk("drain1.wd",     64'(out_wd),    64'd2);
        chk("drain1.wdata",  64'(out_wdata), 64'h222);
        chk("drain1.wreg",   64'(out_wreg),  64'd0);
        chk("drain1.occ",    64'(occupancy), 64'd1);
        chk("drain1.in_rdy", 64'(in_ready),  64'd1);
        step();
        chk_empty("drain2");

        // Streaming: one entry per cycle, never back-pressured.
        for (int i = 0; i < 16; i++) begin
            e_x = '{wd: 5'(i), wreg: 1'b1, wdata: 32'h1000 + 32'(i), payload: 8'(i)};
            drive(1'b1, e_x);
            step();
            chk("stream.valid",  64'(out_valid), 64'd1);
            chk("stream.wd",     64'(out_wd),    64'(i));
            chk("stream.wdata",  64'(out_wdata), 64'h1000 + 64'(i));
            chk("stream.in_rdy", 64'(in_ready),  64'd1);
            chk("stream.occ",    64'(occupancy), 64'd1);
        end
        drive(1'b0, e_nop);
        step();
        chk_empty("stream_end");

        // Flush a full block while a push is offered.
        out_ready = 1'b0;
        drive(1'b1, e_a); step();
        drive(1'b1, e_b); step();
        chk("pre_flush.occ", 64'(occupancy), 64'd2);
        flush = 1'b1;
        e_x = '{wd: 5'd9, wreg: 1'b1, wdata: 32'h999, payload: 8'h99};
        drive(1'b1, e_x);
        step();
        flush = 1'b0;
        drive(1'b0, e_nop);
        chk_empty("flush");
        out_ready = 1'b1;
        step();
        chk_empty("flush_after");

`ifdef PIPE_SKID_FWD_EN
        // Bypass tracks the youngest valid entry.
        out_ready = 1'b0;
        chk("fwd_empty.wd", 64'(fwd_wd), 64'd0);
        e_a = '{wd: 5'd3, wreg: 1'b1, wdata: 32'h333, payload: 8'h03};
        e_b = '{wd: 5'd7, wreg: 1'b1, wdata: 32'h777, payload: 8'h07};
        drive(1'b1, e_a); step();
        chk("fwd_head.wd", 64'(fwd_wd), 64'd3);
        drive(1'b1, e_b); step();
        drive(1'b0, e_nop);
        chk("fwd_skid.wd",    64'(fwd_wd),    64'd7);
        chk("fwd_skid.wdata", 64'(fwd_wdata), 64'h777);
        chk("fwd_skid.wreg",  64'(fwd_wreg),  64'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("fwd_pop.wd",     64'(fwd_wd),    64'd7);
        chk("fwd_pop.out_wd", 64'(out_wd),    64'd7);
        chk("fwd_pop.occ",    64'(occupancy), 64'd1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("fwd_flush.wd",    64'(fwd_wd),    64'd0);
        chk("fwd_flush.wdata", 64'(fwd_wdata), 64'd0);
`endif

        // Reset mid-transfer discards everything.
        out_ready = 1'b0;
        drive(1'b1, e_a); step();
        drive(1'b1, e_b); step();
        chk("pre_rst.occ", 64'(occupancy), 64'd2);
        rst = 1'b1;
        drive(1'b1, e_x);
        step();
        drive(1'b0, e_nop);
        rst = 1'b0;
        chk_empty("mid_reset");
        out_ready = 1'b1;
        step();
        chk_empty("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
